axi_stream_remove_header: RTL and testbench
===========================================

AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), byte-index width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports valid_in/ready_in (input/output, 1), data_in (input, DATA_WD), keep_in (input, DATA_BYTE_WD), last_in (input, 1): upstream AXI-Stream.
REQ-007 SHALL have ports valid_out/ready_out (output/input, 1), data_out (output, DATA_WD), keep_out (output, DATA_BYTE_WD), last_out (output, 1): downstream AXI-Stream.
REQ-008 SHALL have ports valid_remove (input, 1), byte_remove_cnt (input, BYTE_CNT_WD+1, range 0..DATA_BYTE_WD) and ready_remove (output, 1): per-packet strip command.

Function
REQ-009 SHALL use MSB-first byte order: byte 0 = data[DATA_WD-1 -: 8], qualified by keep[DATA_BYTE_WD-1]; keep is MSB-contiguous; only the last beat may be partial.
REQ-010 SHALL implement states IDLE, FIRST, STREAM, FLUSH; reset state IDLE.
REQ-011 SHALL assert ready_remove only in IDLE; valid_remove && ready_remove latches byte_remove_cnt as c and moves to FIRST.
REQ-012 SHALL drive ready_in = (state is FIRST or STREAM) && (!valid_out || ready_out); ready_in SHALL be 0 in IDLE and FLUSH.
REQ-013 SHALL, on the FIRST beat, discard its leading c bytes and hold the remaining DATA_BYTE_WD-c bytes in a residual register; no output unless c=0 (beat passes through unchanged).
REQ-014 SHALL, on each STREAM beat, emit {residual bytes, leading c bytes of data_in}, keep all ones, and reload the residual with the trailing DATA_BYTE_WD-c bytes of data_in.
REQ-015 SHALL, with v = valid bytes of the last input beat: if v <= c, emit residual + v bytes with last_out=1 and go to IDLE; if v > c, emit a full beat, go to FLUSH, then emit the remaining v-c bytes with last_out=1 and go to IDLE after that beat is accepted.
REQ-016 SHALL drop the whole packet (no output, IDLE) when the packet ends inside the stripped region (FIRST beat with last_in and v <= c).
REQ-017 SHALL zero data_out bytes whose keep_out bit is 0.
REQ-018 SHALL register all outputs; output beat held stable while valid_out && !ready_out; latency input accept -> valid_out is 1 cycle.
REQ-019 SHALL sustain one beat per cycle in STREAM with ready_out held high.
REQ-020 SHALL allow command acceptance in IDLE while the final output beat still waits for ready_out.

Reset
REQ-021 SHALL, while rst=1 (including mid-packet), force IDLE, valid_out=0, last_out=0, data_out=0, keep_out=0, ready_in=0, ready_remove=0, residual=0; partial packet discarded.
REQ-022 SHALL assert ready_remove in the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, with AXIS_RH_HEADER_OUT_EN defined, add outputs header_valid (1) and header_data (DATA_WD): one-cycle pulse after the FIRST beat is accepted, carrying the stripped c bytes left-aligned, other bytes zero; without the macro these ports and their logic SHALL not exist and behaviour is otherwise identical.

Structure
REQ-024 SHALL place the state enum and byte-lane helper constants in shared package axi_stream_pkg.
REQ-025 SHALL implement the residual/merge datapath as sub-module axis_byte_realign (inputs residual, data_in, c; outputs merged beat and next residual).

Verification
REQ-026 c=1; beats A1A2A3A4, B1B2B3B4, last C1C2C3C4 keep 1100 -> A2A3A4B1 /F, B2B3B4C1 /F, C2000000 /1000 last.
REQ-027 c=2, same packet -> A3A4B1B2 /F, B3B4C1C2 /F last; no FLUSH beat.
REQ-028 c=0, 3-beat packet -> output identical to input, 1-cycle latency, 3 consecutive valid_out cycles.
REQ-029 c=4, single beat last keep 1111 -> no output, ready_remove high again next cycle.
REQ-030 c=1 stream with ready_out low 8 cycles mid-packet -> data_out/keep_out stable, ready_in=0, no beat lost or duplicated.
REQ-031 rst pulse mid-packet -> all outputs zero, next packet with c=3 produces correct bytes.

Source files
------------

// File: rtl/axi_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_pkg
// Description : Shared types and byte-lane constants for the AXI-Stream
//               header-removal block (FSM state encoding, byte width).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_pkg;

    // Packet-level sequencing of the header stripper
    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // waiting for a strip command
        FIRST  = 2'd1,   // first beat of the packet: strip c leading bytes
        STREAM = 2'd2,   // body beats: merge residual with incoming bytes
        FLUSH  = 2'd3    // emit the leftover tail bytes of the last beat
    } rh_state_e;

    // Width of one byte lane in bits
    localparam int C_BYTE_W = 8;

endpackage : axi_stream_pkg
`default_nettype wire

// File: rtl/axis_byte_realign.sv
`default_nettype none
// ============================================================================
// Module      : axis_byte_realign
// Description : Byte realignment datapath. Appends the leading c bytes of the
//               incoming beat to the left-aligned residual and produces the
//               trailing DATA_BYTE_WD-c bytes as the next left-aligned residual.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_byte_realign
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]   residual,
    input  logic [DATA_WD-1:0]   data_in,
    input  logic [BYTE_CNT_WD:0] c,
    output logic [DATA_WD-1:0]   merged,
    output logic [DATA_WD-1:0]   next_residual
);

    // Residual occupies the top DATA_BYTE_WD-c lanes, so the new bytes are
    // shifted down by that many lanes; the remainder moves up by c lanes.
    always_comb begin
        int sh_r;
        int sh_l;
        sh_r          = (DATA_BYTE_WD - int'(c)) * C_BYTE_W;
        sh_l          = int'(c) * C_BYTE_W;
        merged        = residual | (data_in >> sh_r);
        next_residual = data_in << sh_l;
    end

endmodule : axis_byte_realign
`default_nettype wire

// File: rtl/axi_stream_remove_header.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_remove_header
// Description : Strips a per-packet number of leading bytes (0..DATA_BYTE_WD)
//               from an MSB-first AXI-Stream packet and re-packs the rest.
//               Optional macro AXIS_RH_HEADER_OUT_EN adds header_valid /
//               header_data outputs carrying the stripped bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_remove_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    // upstream
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    // downstream
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    // strip command
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
    output logic                    ready_remove
`ifdef AXIS_RH_HEADER_OUT_EN
    ,
    output logic                    header_valid,
    output logic [DATA_WD-1:0]      header_data
`endif
);

    // Top n keep bits set (keep is MSB-contiguous)
    function automatic logic [DATA_BYTE_WD-1:0] f_keep_top(input int n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < n) k[DATA_BYTE_WD-1-i] = 1'b1;
        end
        return k;
    endfunction

    // Expand keep bits to a bit mask over the data lanes
    function automatic logic [DATA_WD-1:0] f_byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*C_BYTE_W +: C_BYTE_W] = {C_BYTE_W{k[i]}};
        end
        return m;
    endfunction

    // Number of valid bytes in a beat
    function automatic int f_count(input logic [DATA_BYTE_WD-1:0] k);
        int n;
        n = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (k[i]) n++;
        end
        return n;
    endfunction

    rh_state_e                 state_q,      state_d;
    logic [BYTE_CNT_WD:0]      cnt_q,        cnt_d;
    logic [DATA_WD-1:0]        resid_q,      resid_d;
    logic [DATA_BYTE_WD-1:0]   flush_keep_q, flush_keep_d;
    logic                      valid_out_q,  valid_out_d;
    logic [DATA_WD-1:0]        data_out_q,   data_out_d;
    logic [DATA_BYTE_WD-1:0]   keep_out_q,   keep_out_d;
    logic                      last_out_q,   last_out_d;
`ifdef AXIS_RH_HEADER_OUT_EN
    logic                      header_valid_q, header_valid_d;
    logic [DATA_WD-1:0]        header_data_q,  header_data_d;
`endif

    logic [DATA_WD-1:0]        w_din_m;
    logic [DATA_WD-1:0]        w_merged;
    logic [DATA_WD-1:0]        w_next_resid;
    logic                      w_slot_free;
    logic                      w_in_fire;
    int                        w_v;
    int                        w_c;

    assign w_din_m     = data_in & f_byte_mask(keep_in);
    assign w_v         = f_count(keep_in);
    assign w_c         = int'(cnt_q);
    assign w_slot_free = !valid_out_q || ready_out;
    assign ready_in    = ((state_q == FIRST) || (state_q == STREAM)) && w_slot_free;
    assign w_in_fire   = valid_in && ready_in;
    assign ready_remove = (state_q == IDLE) && !rst;

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;
`ifdef AXIS_RH_HEADER_OUT_EN
    assign header_valid = header_valid_q;
    assign header_data  = header_data_q;
`endif

    axis_byte_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .residual      (resid_q),
        .data_in       (w_din_m),
        .c             (cnt_q),
        .merged        (w_merged),
        .next_residual (w_next_resid)
    );

    // Next-state and next-output computation for the strip sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resid_d      = resid_q;
        flush_keep_d = flush_keep_q;
        valid_out_d  = valid_out_q && !ready_out;
        data_out_d   = data_out_q;
        keep_out_d   = keep_out_q;
        last_out_d   = last_out_q;
`ifdef AXIS_RH_HEADER_OUT_EN
        header_valid_d = 1'b0;
        header_data_d  = header_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_remove) begin
                    cnt_d   = byte_remove_cnt;
                    resid_d = '0;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (w_in_fire) begin
`ifdef AXIS_RH_HEADER_OUT_EN
                    header_valid_d = 1'b1;
                    header_data_d  = w_din_m & f_byte_mask(f_keep_top(w_c));
`endif
                    if (w_c == 0) begin
                        // nothing to strip: the packet passes straight through
                        valid_out_d = 1'b1;
                        data_out_d  = w_din_m;
                        keep_out_d  = keep_in;
                        last_out_d  = last_in;
                        state_d     = last_in ? IDLE : STREAM;
                    end else begin
                        resid_d = w_next_resid;
                        if (!last_in) begin
                            state_d = STREAM;
                        end else if (w_v <= w_c) begin
                            // packet ended inside the header: drop it
                            resid_d = '0;
                            state_d = IDLE;
                        end else begin
                            flush_keep_d = f_keep_top(w_v - w_c);
                            state_d      = FLUSH;
                        end
                    end
                end
            end
            STREAM: begin
                if (w_in_fire) begin
                    valid_out_d = 1'b1;
                    if (w_c == 0) begin
                        data_out_d = w_din_m;
                        keep_out_d = keep_in;
                        last_out_d = last_in;
                        if (last_in) state_d = IDLE;
                    end else begin
                        data_out_d = w_merged;
                        resid_d    = w_next_resid;
                        if (!last_in) begin
                            keep_out_d = '1;
                            last_out_d = 1'b0;
                        end else if (w_v <= w_c) begin
                            // tail fits in this beat
                            keep_out_d = f_keep_top(DATA_BYTE_WD - w_c + w_v);
                            last_out_d = 1'b1;
                            resid_d    = '0;
                            state_d    = IDLE;
                        end else begin
                            keep_out_d   = '1;
                            last_out_d   = 1'b0;
                            flush_keep_d = f_keep_top(w_v - w_c);
                            state_d      = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = resid_q;
                    keep_out_d  = flush_keep_q;
                    last_out_d  = 1'b1;
                    resid_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, residual and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resid_q      <= '0;
            flush_keep_q <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            keep_out_q   <= '0;
            last_out_q   <= 1'b0;
`ifdef AXIS_RH_HEADER_OUT_EN
            header_valid_q <= 1'b0;
            header_data_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resid_q      <= resid_d;
            flush_keep_q <= flush_keep_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            keep_out_q   <= keep_out_d;
            last_out_q   <= last_out_d;
`ifdef AXIS_RH_HEADER_OUT_EN
            header_valid_q <= header_valid_d;
            header_data_q  <= header_data_d;
`endif
        end
    end

endmodule : axi_stream_remove_header
`default_nettype wire

// File: tb/tb_axi_stream_remove_header.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_remove_header
// Description : Scoreboard bench for axi_stream_remove_header (32-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_remove_header;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_remove, ready_remove;
    logic [2:0]  byte_remove_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    run     = 0;
    int    max_run = 0;

    always #5 clk = ~clk;

    axi_stream_remove_header #(.DATA_WD(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .valid_remove    (valid_remove),
        .byte_remove_cnt (byte_remove_cnt),
        .ready_remove    (ready_remove)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        int n;
        n = 0;
        valid_remove    = 1'b1;
        byte_remove_cnt = c;
        forever begin
            @(negedge clk);
            if (ready_remove) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL cmd_timeout: got ready_remove 0 expected 1");
                break;
            end
        end
        tick();
        valid_remove = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input bit chk_lat);
        int n;
        n = 0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        forever begin
            @(negedge clk);
            if (ready_in) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL beat_timeout: got ready_in 0 expected 1");
                break;
            end
        end
        tick();
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        if (chk_lat) chk("latency_valid", valid_out, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    // Scoreboard monitor: compare each beat handed over downstream
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got data %h keep %b last %b expected none",
                             data_out, keep_out, last_out);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_data", data_out, e.d);
                    chk("out_keep", keep_out, e.k);
                    chk("out_last", last_out, e.l);
                end
            end
        end
    end

    // Longest run of consecutive valid_out cycles
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out) run++; else run = 0;
            if (run > max_run) max_run = run;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_d;
        logic [3:0]  hold_k;
        int          n;
        rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b1; valid_remove = 1'b0; byte_remove_cnt = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_ready_remove", ready_remove, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_remove_after_rst", ready_remove, 1);
        tick();

        // c=1, tail longer than c -> FLUSH beat
        push(32'hA2A3A4B1, 4'hF, 0);
        push(32'hB2B3B4C1, 4'hF, 0);
        push(32'hC2000000, 4'b1000, 1);
        send_cmd(3'd1);
        send_beat(32'hA1A2A3A4, 4'hF, 0, 0);
        send_beat(32'hB1B2B3B4, 4'hF, 0, 0);
        send_beat(32'hC1C2C3C4, 4'b1100, 1, 0);
        drain();

        // c=2, tail fits -> no FLUSH beat
        push(32'hA3A4B1B2, 4'hF, 0);
        push(32'hB3B4C1C2, 4'hF, 1);
        send_cmd(3'd2);
        send_beat(32'hA1A2A3A4, 4'hF, 0, 0);
        send_beat(32'hB1B2B3B4, 4'hF, 0, 0);
        send_beat(32'hC1C2C3C4, 4'b1100, 1, 0);
        drain();

        // c=0 pass-through with 1-cycle latency and back-to-back beats
        max_run = 0;
        push(32'h01020304, 4'hF, 0);
        push(32'h05060708, 4'hF, 0);
        push(32'h090A0000, 4'b1100, 1);
        send_cmd(3'd0);
        send_beat(32'h01020304, 4'hF, 0, 1);
        send_beat(32'h05060708, 4'hF, 0, 1);
        send_beat(32'h090A0B0C, 4'b1100, 1, 1);
        drain();
        chk("c0_consecutive_valid", max_run, 3);

        // c=4, single full beat -> dropped, back to IDLE at once
        send_cmd(3'd4);
        send_beat(32'hDEADBEEF, 4'hF, 1, 0);
        chk("c4_ready_remove", ready_remove, 1);
        chk("c4_no_output", valid_out, 0);
        repeat (3) tick();
        chk("c4_no_output_later", valid_out, 0);

        // c=1 with downstream stalled 8 cycles mid-packet
        push(32'hD2D3D4E1, 4'hF, 0);
        push(32'hE2E3E4F1, 4'hF, 0);
        push(32'hF2F3F490, 4'hF, 0);
        push(32'h91920000, 4'b1100, 1);
        ready_out = 1'b0;
        send_cmd(3'd1);
        fork
            begin
                send_beat(32'hD1D2D3D4, 4'hF, 0, 0);
                send_beat(32'hE1E2E3E4, 4'hF, 0, 0);
                send_beat(32'hF1F2F3F4, 4'hF, 0, 0);
                send_beat(32'h90919293, 4'b1110, 1, 0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!valid_out && n < 50);
                chk("stall_valid_seen", valid_out, 1);
                hold_d = data_out;
                hold_k = keep_out;
                repeat (8) begin
                    @(negedge clk);
                    chk("stall_data", data_out, hold_d);
                    chk("stall_keep", keep_out, hold_k);
                    chk("stall_valid", valid_out, 1);
                    chk("stall_ready_in", ready_in, 0);
                end
                tick();
                ready_out = 1'b1;
            end
        join
        drain();

        // reset mid-packet, then a clean c=3 packet
        ready_out = 1'b0;
        send_cmd(3'd2);
        send_beat(32'h10111213, 4'hF, 0, 0);
        send_beat(32'h14151617, 4'hF, 0, 0);
        chk("pre_rst_valid_out", valid_out, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_keep_out", keep_out, 0);
        chk("midrst_last_out", last_out, 0);
        chk("midrst_ready_in", ready_in, 0);
        chk("midrst_ready_remove", ready_remove, 0);
        tick();
        rst = 1'b0;
        ready_out = 1'b1;
        tick();
        push(32'h44556677, 4'hF, 0);
        push(32'h88990000, 4'b1100, 1);
        send_cmd(3'd3);
        send_beat(32'h11223344, 4'hF, 0, 0);
        send_beat(32'h55667788, 4'hF, 0, 0);
        send_beat(32'h99AABBCC, 4'b1000, 1, 0);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_stream_remove_header
`default_nettype wire
